// File: rtl/char_rot_pkg.sv
// Shared types, sizes and rotate helpers for the HEX character rotation path.
package char_rot_pkg;
  localparam int CHAR_W       = 3;
  localparam int NUM_CHARS    = 6;
  localparam int WORD_W       = CHAR_W * NUM_CHARS;
  localparam int OFS_W        = 3;
  localparam int TICK_DIV_DEF = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PAUSE = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  // Field i of the result takes source field (i - ofs) mod NUM_CHARS.
  function automatic logic [WORD_W-1:0] rotate_word(input logic [WORD_W-1:0] w,
                                                     input logic [OFS_W-1:0]  ofs);
    logic [WORD_W-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < NUM_CHARS; i++) begin
      for (int o = 0; o < NUM_CHARS; o++) begin
        src = i - o;
        if (src < 0) src = src + NUM_CHARS;
        if (ofs == OFS_W'(o)) r[i*CHAR_W +: CHAR_W] = w[src*CHAR_W +: CHAR_W];
      end
    end
    return r;
  endfunction

  function automatic logic [OFS_W-1:0] next_offset(input logic [OFS_W-1:0] ofs,
                                                   input logic             d);
    logic [OFS_W-1:0] n;
    if (!d) n = (ofs == OFS_W'(NUM_CHARS - 1)) ? '0 : ofs + OFS_W'(1);
    else    n = (ofs == '0) ? OFS_W'(NUM_CHARS - 1) : ofs - OFS_W'(1);
    return n;
  endfunction
endpackage

// File: rtl/char_rotate_ctrl_if.sv
// Control and display bus of the character rotation sequencer.
interface char_rotate_ctrl_if;
  import char_rot_pkg::*;

  logic [WORD_W-1:0] SW;
  logic              load;
  logic              run;
  logic              step;
  logic              dir;
  logic [WORD_W-1:0] disp_word;
  logic [OFS_W-1:0]  offset;
  logic [1:0]        state;
  logic              tick;

  modport master (output SW, load, run, step, dir,
                  input  disp_word, offset, state, tick);
  modport slave  (input  SW, load, run, step, dir,
                  output disp_word, offset, state, tick);
endinterface

// File: rtl/tick_prescaler.sv
// Counts 0..TICK_DIV-1 while enabled, holds otherwise; tc is combinational at the terminal count.
// Latency: tc asserts in the cycle the count sits at TICK_DIV-1; clr wins over en.
module tick_prescaler #(
  parameter int CNT_W    = 26,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == TERM);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/char_rotate_ctrl.sv
// Captures a six-character word and rotates it across HEX5..HEX0, free-running or single-stepped.
// Latency: outputs registered, visible one cycle after load/step/terminal count; no backpressure.
module char_rotate_ctrl
  import char_rot_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CNT_W    = 26
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  char_rotate_ctrl_if.slave bus
);
  state_t            st;
  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] disp_reg;
  logic [OFS_W-1:0]  ofs;
  logic [OFS_W-1:0]  ofs_nxt;
  logic              tick_reg;
  logic              tc;
  logic              do_rot;

  tick_prescaler #(
    .CNT_W    (CNT_W),
    .TICK_DIV (TICK_DIV)
  ) u_presc (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .en       (st == ST_RUN),
    .clr      (bus.load),
    .tc       (tc)
  );

  // Load outranks any rotation on the same edge.
  assign do_rot  = !bus.load && (tc || (st == ST_PAUSE && bus.step));
  assign ofs_nxt = next_offset(ofs, bus.dir);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      st       <= ST_IDLE;
      word_reg <= '0;
      disp_reg <= '0;
      ofs      <= '0;
      tick_reg <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (bus.load) begin
        word_reg <= bus.SW;
        disp_reg <= bus.SW;
        ofs      <= '0;
        st       <= bus.run ? ST_RUN : ST_PAUSE;
      end else begin
        if (do_rot) begin
          ofs      <= ofs_nxt;
          disp_reg <= rotate_word(word_reg, ofs_nxt);
          tick_reg <= 1'b1;
        end
        case (st)
          ST_IDLE:  st <= ST_IDLE;
          ST_PAUSE: if (bus.run)  st <= ST_RUN;
          ST_RUN:   if (!bus.run) st <= ST_PAUSE;
          default:  st <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.disp_word = disp_reg;
  assign bus.offset    = ofs;
  assign bus.state     = st;
  assign bus.tick      = tick_reg;
endmodule

// File: tb/tb_char_rotate_ctrl.sv
// Directed bench for char_rotate_ctrl with a 4-cycle rotation period.
module tb_char_rotate_ctrl;
  logic clk = 1'b0;
  logic resetn;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   saw_tick;

  logic [17:0] rot_exp [6] = '{18'o123450, 18'o234501, 18'o345012,
                               18'o450123, 18'o501234, 18'o012345};

  char_rotate_ctrl_if bus();

  char_rotate_ctrl #(.TICK_DIV(4), .CNT_W(26)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [17:0] w);
    bus.SW   = w;
    bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
  endtask

  task automatic do_step(input logic d);
    bus.dir  = d;
    bus.step = 1'b1;
    cyc(1);
    bus.step = 1'b0;
  endtask

  initial begin
    resetn   = 1'b0;
    bus.SW   = '0;
    bus.load = 1'b0;
    bus.run  = 1'b0;
    bus.step = 1'b0;
    bus.dir  = 1'b0;
    #3;
    chk("rst_disp",  32'(bus.disp_word), 32'h0);
    chk("rst_ofs",   32'(bus.offset),    32'h0);
    chk("rst_state", 32'(bus.state),     32'h0);
    chk("rst_tick",  32'(bus.tick),      32'h0);
    cyc(2);
    resetn = 1'b1;

    // 1: run and step have no effect before the first load
    bus.run  = 1'b1;
    saw_tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.step = (i % 3 == 0);
      cyc(1);
      if (bus.tick) saw_tick = 1'b1;
    end
    bus.step = 1'b0;
    chk("t1_state", 32'(bus.state),     32'h0);
    chk("t1_disp",  32'(bus.disp_word), 32'h0);
    chk("t1_tick",  32'(saw_tick),      32'h0);

    // 2: free-run through a full revolution
    do_load(18'o012345);
    chk("t2_state", 32'(bus.state),     32'h2);
    chk("t2_disp0", 32'(bus.disp_word), 32'(18'o012345));
    chk("t2_ofs0",  32'(bus.offset),    32'h0);
    chk("t2_tick0", 32'(bus.tick),      32'h0);
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        chk("t2_tick_lo", 32'(bus.tick), 32'h0);
      end
      cyc(1);
      chk("t2_tick_hi", 32'(bus.tick),      32'h1);
      chk("t2_disp",    32'(bus.disp_word), 32'(rot_exp[k]));
      chk("t2_ofs",     32'(bus.offset),    32'((k + 1) % 6));
    end

    // 3: single-step wrap both directions
    bus.run = 1'b0;
    cyc(1);
    chk("t3_state", 32'(bus.state), 32'h1);
    do_step(1'b1);
    chk("t3_r_ofs",  32'(bus.offset),    32'h5);
    chk("t3_r_disp", 32'(bus.disp_word), 32'(18'o501234));
    chk("t3_r_tick", 32'(bus.tick),      32'h1);
    cyc(1);
    chk("t3_r_tick_off", 32'(bus.tick), 32'h0);
    do_step(1'b0);
    chk("t3_l_ofs",  32'(bus.offset),    32'h0);
    chk("t3_l_disp", 32'(bus.disp_word), 32'(18'o012345));
    chk("t3_l_tick", 32'(bus.tick),      32'h1);
    cyc(1);
    chk("t3_l_tick_off", 32'(bus.tick),   32'h0);
    chk("t3_l_ofs_hold", 32'(bus.offset), 32'h0);

    // 4: pause holds the prescaler at 2, resume continues from there
    bus.run = 1'b1;
    do_load(18'o012345);
    cyc(1);
    bus.run = 1'b0;
    cyc(1);
    chk("t4_paused", 32'(bus.state), 32'h1);
    saw_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (bus.tick) saw_tick = 1'b1;
    end
    chk("t4_no_tick", 32'(saw_tick), 32'h0);
    bus.run = 1'b1;
    cyc(1);
    chk("t4_resumed", 32'(bus.state), 32'h2);
    chk("t4_tick_r1", 32'(bus.tick),  32'h0);
    cyc(1);
    chk("t4_tick_r2", 32'(bus.tick),  32'h0);
    cyc(1);
    chk("t4_tick_r3", 32'(bus.tick),      32'h1);
    chk("t4_ofs",     32'(bus.offset),    32'h1);
    chk("t4_disp",    32'(bus.disp_word), 32'(18'o123450));

    // 5: load on the terminal-count edge suppresses the rotation
    cyc(3);
    do_load(18'o777000);
    chk("t5_ofs",   32'(bus.offset),    32'h0);
    chk("t5_disp",  32'(bus.disp_word), 32'(18'o777000));
    chk("t5_tick",  32'(bus.tick),      32'h0);
    chk("t5_state", 32'(bus.state),     32'h2);
    cyc(4);
    chk("t5_next_tick", 32'(bus.tick),      32'h1);
    chk("t5_next_disp", 32'(bus.disp_word), 32'(18'o770007));

    // 6: async reset mid-run at offset 3
    cyc(8);
    chk("t6_ofs3",  32'(bus.offset),    32'h3);
    chk("t6_disp3", 32'(bus.disp_word), 32'(18'o000777));
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_async_disp",  32'(bus.disp_word), 32'h0);
    chk("t6_async_ofs",   32'(bus.offset),    32'h0);
    chk("t6_async_tick",  32'(bus.tick),      32'h0);
    chk("t6_async_state", 32'(bus.state),     32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    cyc(2);
    chk("t6_post_state", 32'(bus.state),     32'h0);
    chk("t6_post_disp",  32'(bus.disp_word), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
